alu_share_arbiter: RTL

//  Shares one 32-bit ALU (8 ops: ADD/SUB/AND/OR/XOR/NAND/NOR/XNOR, 3-bit op code, zero flag)

---
 rtl/alu_share_if.sv | 32 +++
 rtl/alu_share_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu_share_if.sv
// Request, ALU and response bundle between the issue logic, the shared ALU and the arbiter.
interface alu_share_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_op1;
  logic [NUM_REQ*DATA_W-1:0] req_op2;
  logic [NUM_REQ*3-1:0]      req_alu_op;
  logic [DATA_W-1:0]         alu_operand1;
  logic [DATA_W-1:0]         alu_operand2;
  logic [2:0]                alu_op;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_zero;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;

  modport slave (
    input  req_valid, req_op1, req_op2, req_alu_op, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_operand1, alu_operand2, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req_valid, req_op1, req_op2, req_alu_op, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_operand1, alu_operand2, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU among NUM_REQ requesters.
// One op in flight: grant in IDLE, ALU settles in EXEC, response held in RESP.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e                         state_q, state_d;
  logic [ID_W-1:0]                rr_q, rr_d;
  logic [ID_W-1:0]                id_q, id_d;
  logic [DATA_W-1:0]              op1_q, op1_d, op2_q, op2_d;
  logic [DATA_W-1:0]              res_q, res_d;
  logic [2:0]                     aop_q, aop_d;
  logic                           zero_q, zero_d, vld_q, vld_d;

  logic                           gnt_any;
  logic [ID_W-1:0]                gnt_idx, scan, rr_nxt;
  logic [NUM_REQ-1:0]             gnt_oh;
  logic [NUM_REQ-1:0][DATA_W-1:0] op1_a, op2_a;
  logic [NUM_REQ-1:0][2:0]        aop_a;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign op1_a[g] = bus.req_op1[g*DATA_W +: DATA_W];
    assign op2_a[g] = bus.req_op2[g*DATA_W +: DATA_W];
    assign aop_a[g] = bus.req_alu_op[g*3 +: 3];
  end

  // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!gnt_any && bus.req_valid[scan]) begin
        gnt_any      = 1'b1;
        gnt_idx      = scan;
        gnt_oh[scan] = 1'b1;
      end
    end
  end

  assign rr_nxt = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    aop_d   = aop_q;
    res_d   = res_q;
    zero_d  = zero_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        op1_d   = op1_a[gnt_idx];
        op2_d   = op2_a[gnt_idx];
        aop_d   = aop_a[gnt_idx];
        id_d    = gnt_idx;
        rr_d    = rr_nxt;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = bus.alu_result;
        zero_d  = bus.alu_zero;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      aop_q   <= 3'b000;
      res_q   <= '0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      aop_q   <= aop_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
    end
  end

  // Gated by rst_n so the grant is silent while reset is held with requests pending.
  assign bus.req_ready    = (state_q == IDLE && rst_n) ? gnt_oh : '0;
  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_op       = aop_q;
  assign bus.rsp_valid    = vld_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_zero     = zero_q;
endmodule
